// File: rtl/vmem_arb.sv
// Framebuffer port arbiter: scan-out reads beat clear-screen fills, which beat CPU writes.
// Only one single-port memory access is granted per cycle.
module vmem_arb #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    input  logic          cpu_valid,
    output logic          cpu_ready,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          wr_drop,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // PIXELS carries one extra bit so a framebuffer of exactly 2^AW words still compares correctly.
    localparam logic [AW:0]   PIXELS    = (AW+1)'(H_RES * V_RES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_fill_cnt;
    logic [DW-1:0] r_fill_color;
    logic          r_vga_rd_p1;
    logic [DW-1:0] r_vga_data_p1;

    logic w_idle;
    logic w_vga_rd;
    logic w_fill_wr;
    logic w_cpu_ready;
    logic w_cpu_xfer;
    logic w_cpu_inrange;

    assign w_idle        = (r_state == IDLE);
    assign w_vga_rd      = !rst && vga_req;
    assign w_fill_wr     = !rst && (r_state == FILL) && !vga_req;
    assign w_cpu_ready   = !rst && w_idle && !vga_req && !fill_start;
    assign w_cpu_xfer    = cpu_valid && w_cpu_ready;
    assign w_cpu_inrange = ({1'b0, cpu_addr} < PIXELS);

    assign cpu_ready = w_cpu_ready;
    assign fill_busy = !rst && (r_state == FILL);
    assign wr_drop   = w_cpu_xfer && !w_cpu_inrange;
    assign vga_data  = r_vga_data_p1;

    // Memory port mux, priority order: scan-out read, fill write, CPU write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_vga_rd) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
        end else if (w_fill_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_fill_cnt;
            mem_wdata = r_fill_color;
        end else if (w_cpu_xfer && w_cpu_inrange) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fill_cnt    <= '0;
            r_fill_color  <= '0;
            r_vga_rd_p1   <= 1'b0;
            r_vga_data_p1 <= '0;
        end else begin
            // Read-data stage: memory returns data the cycle after the read.
            r_vga_rd_p1 <= vga_req;
            if (r_vga_rd_p1) begin
                r_vga_data_p1 <= mem_rdata;
            end

            case (r_state)
                IDLE: begin
                    if (fill_start) begin
                        r_state      <= FILL;
                        r_fill_cnt   <= '0;
                        r_fill_color <= fill_color;
                    end
                end
                FILL: begin
                    // A scan-out read stalls the fill without losing its place.
                    if (!vga_req) begin
                        if (r_fill_cnt == LAST_ADDR) begin
                            r_state    <= IDLE;
                            r_fill_cnt <= '0;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_arb.sv
// Directed plus randomized bench for vmem_arb on a reduced 16x8 framebuffer,
// with a behavioural framebuffer image predicted from the arbitration rules.
module tb_vmem_arb;

    localparam int H   = 16;
    localparam int V   = 8;
    localparam int AW  = 8;
    localparam int DW  = 24;
    localparam int PIX = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          cpu_valid;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          fill_start;
    logic [DW-1:0] fill_color;
    logic          fill_busy;
    logic          wr_drop;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0]    fb     [0:(1<<AW)-1];
    logic [DW-1:0]    exp_fb [0:PIX-1];
    logic [AW+DW-1:0] wlog   [$];
    int busy_n;
    int rdy_viol;
    logic [DW-1:0] last_vga;

    always #5 clk = ~clk;

    vmem_arb #(.H_RES(H), .V_RES(V), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy), .wr_drop(wr_drop),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && mem_we) fb[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= fb[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_fill(input int stall_at, input int stall_len, input int max_cyc,
                            input int restart_at);
        int n;
        n = 0;
        wlog.delete();
        busy_n = 0;
        rdy_viol = 0;
        while (n < max_cyc) begin
            vga_req    = (n >= stall_at) && (n < stall_at + stall_len);
            vga_addr   = AW'(n % PIX);
            fill_start = (n == restart_at);
            fill_color = DW'($urandom);
            #1;
            if (!fill_busy) break;
            busy_n++;
            if (cpu_ready) rdy_viol++;
            if (mem_en && mem_we) wlog.push_back({mem_addr, mem_wdata});
            tick();
            n++;
        end
        vga_req = 1'b0;
        fill_start = 1'b0;
    endtask

    task automatic check_fill(input string tag, input int exp_wr, input logic [DW-1:0] color,
                              input int exp_busy);
        int errs;
        errs = 0;
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        chk({tag, "_nwrites"}, 32'(wlog.size()), 32'(exp_wr));
        foreach (wlog[i]) if (wlog[i] !== {AW'(i), color}) errs++;
        chk({tag, "_addr_seq"}, 32'(errs), 0);
        chk({tag, "_cpu_ready_low"}, 32'(rdy_viol), 0);
    endtask

    task automatic cpu_wr(input int addr, input logic [DW-1:0] data, input string tag);
        cpu_valid = 1'b1;
        cpu_addr  = AW'(addr);
        cpu_wdata = data;
        #1;
        chk({tag, "_ready"}, 32'(cpu_ready), 1);
        if (addr < PIX) begin
            chk({tag, "_en_we"}, 32'({mem_en, mem_we}), 3);
            chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
            chk({tag, "_wdata"}, 32'(mem_wdata), 32'(data));
            chk({tag, "_drop"}, 32'(wr_drop), 0);
            exp_fb[addr] = data;
        end else begin
            chk({tag, "_en"}, 32'(mem_en), 0);
            chk({tag, "_drop"}, 32'(wr_drop), 1);
        end
        tick();
        cpu_valid = 1'b0;
    endtask

    task automatic read_chk(input int addr, input string tag);
        vga_req  = 1'b1;
        vga_addr = AW'(addr);
        #1;
        chk({tag, "_en_we"}, 32'({mem_en, mem_we}), 2);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        tick();
        vga_req = 1'b0;
        tick();
        #1;
        chk({tag, "_data"}, 32'(vga_data), 32'(exp_fb[addr]));
        tick();
        chk({tag, "_hold"}, 32'(vga_data), 32'(exp_fb[addr]));
        last_vga = exp_fb[addr];
        tick();
    endtask

    initial begin
        int wr_n;
        int bz_n;
        int errs;
        logic a_v, b_v;
        logic [DW-1:0] a_e, b_e;

        rst = 1'b1; vga_req = 1'b1; vga_addr = '0; cpu_valid = 1'b1; cpu_addr = '0;
        cpu_wdata = '0; fill_start = 1'b1; fill_color = 24'h00FF00;
        repeat (3) tick();
        #1;
        chk("rst_cpu_ready", 32'(cpu_ready), 0);
        chk("rst_fill_busy", 32'(fill_busy), 0);
        chk("rst_wr_drop", 32'(wr_drop), 0);
        chk("rst_mem_en_we", 32'({mem_en, mem_we}), 0);
        chk("rst_vga_data", 32'(vga_data), 0);
        tick();
        rst = 1'b0; vga_req = 1'b0; cpu_valid = 1'b0; fill_start = 1'b0;
        #1;
        chk("post_rst_idle", 32'(fill_busy), 0);
        chk("post_rst_ready", 32'(cpu_ready), 1);
        tick();

        // Full fill started together with a pending CPU write: fill wins.
        fill_start = 1'b1; fill_color = 24'h0000FF;
        cpu_valid = 1'b1; cpu_addr = 8'd3; cpu_wdata = 24'h123456;
        #1;
        chk("fs_cpu_ready", 32'(cpu_ready), 0);
        chk("fs_mem_en", 32'(mem_en), 0);
        tick();
        run_fill(1000, 0, PIX + 50, -1);
        check_fill("fill", PIX, 24'h0000FF, PIX);
        for (int i = 0; i < PIX; i++) exp_fb[i] = 24'h0000FF;
        chk("postfill_ready", 32'(cpu_ready), 1);
        chk("postfill_wr_addr", 32'(mem_addr), 3);
        chk("postfill_wr_data", 32'(mem_wdata), 32'h123456);
        exp_fb[3] = 24'h123456;
        tick();
        cpu_valid = 1'b0;

        cpu_wr(5, 24'hABCDEF, "cw5");
        read_chk(5, "rd5");
        read_chk(3, "rd3");

        // CPU write blocked by three scan-out reads, then granted exactly once.
        cpu_valid = 1'b1; cpu_addr = 8'd10; cpu_wdata = 24'h112233; vga_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vga_addr = AW'(20 + k);
            #1;
            chk("conf_ready_low", 32'(cpu_ready), 0);
            chk("conf_no_write", 32'(mem_we), 0);
            tick();
        end
        vga_req = 1'b0;
        #1;
        chk("conf_ready", 32'(cpu_ready), 1);
        chk("conf_write", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, 8'd10}));
        chk("conf_wdata", 32'(mem_wdata), 32'h112233);
        exp_fb[10] = 24'h112233;
        tick();
        cpu_valid = 1'b0;
        #1;
        chk("conf_single", 32'(mem_en), 0);
        tick();
        read_chk(10, "rd10");

        cpu_wr(PIX, 24'hDEAD00, "oor_edge");
        cpu_wr(255, 24'hBEEF00, "oor_top");
        cpu_wr(PIX - 1, 24'h777777, "last_in");
        #1;
        chk("drop_one_cycle", 32'(wr_drop), 0);
        tick();
        read_chk(PIX - 1, "rdlast");

        // Fill stalled by 10 scan-out cycles, with a restart attempt that must be ignored.
        fill_start = 1'b1; fill_color = 24'h00FF00;
        #1;
        tick();
        run_fill(30, 10, PIX + 60, 50);
        check_fill("stall", PIX, 24'h00FF00, PIX + 10);
        for (int i = 0; i < PIX; i++) exp_fb[i] = 24'h00FF00;
        tick();

        // Reset in the middle of a fill aborts it.
        fill_start = 1'b1; fill_color = 24'hFF0000;
        #1;
        tick();
        run_fill(1000, 0, 20, -1);
        check_fill("abort", 20, 24'hFF0000, 20);
        for (int i = 0; i < 20; i++) exp_fb[i] = 24'hFF0000;
        rst = 1'b1;
        #1;
        chk("abort_rst_busy", 32'(fill_busy), 0);
        chk("abort_rst_en", 32'(mem_en), 0);
        chk("abort_rst_ready", 32'(cpu_ready), 0);
        tick();
        rst = 1'b0;
        wr_n = 0; bz_n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_en && mem_we) wr_n++;
            if (fill_busy) bz_n++;
            tick();
        end
        chk("abort_no_writes", 32'(wr_n), 0);
        chk("abort_idle", 32'(bz_n), 0);
        read_chk(19, "rd19");
        read_chk(20, "rd20");

        // Randomized CPU traffic competing with scan-out reads.
        a_v = 1'b0; b_v = 1'b0; a_e = '0; b_e = '0;
        for (int j = 0; j < 400; j++) begin
            int ca, va;
            logic vr, cv;
            logic [DW-1:0] cd;
            vr = ($urandom_range(0, 2) == 0);
            cv = ($urandom_range(0, 1) == 1);
            ca = $urandom_range(0, 255);
            va = $urandom_range(0, PIX - 1);
            cd = DW'($urandom);
            vga_req = vr; vga_addr = AW'(va);
            cpu_valid = cv; cpu_addr = AW'(ca); cpu_wdata = cd;
            #1;
            if (b_v) last_vga = b_e;
            chk("rnd_vga_data", 32'(vga_data), 32'(last_vga));
            chk("rnd_ready", 32'(cpu_ready), 32'(!vr));
            if (vr) begin
                chk("rnd_read", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, AW'(va)}));
            end else if (cv && ca < PIX) begin
                chk("rnd_write", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, AW'(ca)}));
                chk("rnd_wdata", 32'(mem_wdata), 32'(cd));
                exp_fb[ca] = cd;
            end else begin
                chk("rnd_no_access", 32'(mem_en), 0);
            end
            chk("rnd_drop", 32'(wr_drop), 32'(!vr && cv && ca >= PIX));
            b_v = a_v; b_e = a_e;
            a_v = vr;  a_e = exp_fb[va];
            tick();
        end
        vga_req = 1'b0; cpu_valid = 1'b0;
        tick();
        errs = 0;
        for (int i = 0; i < PIX; i++) if (fb[i] !== exp_fb[i]) errs++;
        chk("final_image", 32'(errs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
